lock_ctrl: RTL and testbench



---
 rtl/lock_ctrl.sv | 171 +++++++++++++++++
 tb/tb_lock_ctrl.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/lock_ctrl.sv
// Combination-lock sequencer: checks entries, counts failures, times lockout and runs the code-change flow.
// Results are registered one cycle after the cnf edge; cnf and chg in the same cycle resolve to cnf only.
module lock_ctrl #(
  parameter logic [15:0] INIT_CODE  = 16'h1234,
  parameter int          MAX_TRIES  = 3,
  parameter int          SHOW_TICKS = 3,
  parameter int          LOCK_TICKS = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        tick,
  input  logic        cnf,
  input  logic        chg,
  input  logic [15:0] entry,
  output logic        pass,
  output logic        fail,
  output logic        locked,
  output logic        clr_entry,
  output logic [2:0]  st,
  output logic [3:0]  fails,
  output logic [7:0]  remain
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_OPEN     = 3'd1;
  localparam logic [2:0] S_FAILSHOW = 3'd2;
  localparam logic [2:0] S_LOCKOUT  = 3'd3;
  localparam logic [2:0] S_CHG_OLD  = 3'd4;
  localparam logic [2:0] S_CHG_NEW1 = 3'd5;
  localparam logic [2:0] S_CHG_NEW2 = 3'd6;

  localparam int HW = (SHOW_TICKS < 2) ? 1 : $clog2(SHOW_TICKS + 1);

  logic [2:0]    st_q, st_d;
  logic [15:0]   code_q, code_d;
  logic [15:0]   new_q, new_d;
  logic [3:0]    fails_q, fails_d;
  logic [7:0]    remain_q, remain_d;
  logic [HW-1:0] hold_q, hold_d;
  logic          clr_q, clr_d;
  logic          pass_q, fail_q, locked_q;

  logic [3:0]    fails_inc;
  logic          code_match;
  logic          bad_lock;

  assign fails_inc  = (fails_q == 4'd15) ? 4'd15 : fails_q + 4'd1;
  assign code_match = (entry == code_q);
  assign bad_lock   = (fails_inc >= 4'(MAX_TRIES));

  always_comb begin
    st_d     = st_q;
    code_d   = code_q;
    new_d    = new_q;
    fails_d  = fails_q;
    remain_d = remain_q;
    hold_d   = hold_q;
    clr_d    = 1'b0;
    case (st_q)
      S_IDLE: begin
        if (cnf) begin
          clr_d  = 1'b1;
          hold_d = HW'(SHOW_TICKS);
          if (code_match) begin
            st_d    = S_OPEN;
            fails_d = 4'd0;
          end else begin
            fails_d  = fails_inc;
            st_d     = bad_lock ? S_LOCKOUT : S_FAILSHOW;
            remain_d = bad_lock ? 8'(LOCK_TICKS) : 8'd0;
          end
        end else if (chg) begin
          st_d = S_CHG_OLD;
        end
      end
      S_OPEN, S_FAILSHOW: begin
        // Leave on the tick that would take the hold counter to zero.
        if (tick) begin
          hold_d = hold_q - HW'(1);
          if (hold_q <= HW'(1)) st_d = S_IDLE;
        end
      end
      S_LOCKOUT: begin
        if (tick) begin
          if (remain_q <= 8'd1) begin
            st_d     = S_IDLE;
            remain_d = 8'd0;
            fails_d  = 4'd0;
          end else begin
            remain_d = remain_q - 8'd1;
          end
        end
      end
      S_CHG_OLD: begin
        if (cnf) begin
          clr_d  = 1'b1;
          hold_d = HW'(SHOW_TICKS);
          if (code_match) begin
            st_d = S_CHG_NEW1;
          end else begin
            fails_d  = fails_inc;
            st_d     = bad_lock ? S_LOCKOUT : S_FAILSHOW;
            remain_d = bad_lock ? 8'(LOCK_TICKS) : 8'd0;
          end
        end else if (chg) begin
          st_d = S_IDLE;
        end
      end
      S_CHG_NEW1: begin
        if (cnf) begin
          clr_d = 1'b1;
          new_d = entry;
          st_d  = S_CHG_NEW2;
        end else if (chg) begin
          st_d = S_IDLE;
        end
      end
      S_CHG_NEW2: begin
        if (cnf) begin
          clr_d  = 1'b1;
          hold_d = HW'(SHOW_TICKS);
          // A mismatched repeat is not counted as a failed attempt.
          if (entry == new_q) begin
            code_d = new_q;
            st_d   = S_OPEN;
          end else begin
            st_d = S_FAILSHOW;
          end
        end else if (chg) begin
          st_d = S_IDLE;
        end
      end
      default: st_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st_q     <= S_IDLE;
      code_q   <= INIT_CODE;
      new_q    <= 16'd0;
      fails_q  <= 4'd0;
      remain_q <= 8'd0;
      hold_q   <= '0;
      clr_q    <= 1'b0;
      pass_q   <= 1'b0;
      fail_q   <= 1'b0;
      locked_q <= 1'b0;
    end else begin
      st_q     <= st_d;
      code_q   <= code_d;
      new_q    <= new_d;
      fails_q  <= fails_d;
      remain_q <= remain_d;
      hold_q   <= hold_d;
      clr_q    <= clr_d;
      pass_q   <= (st_d == S_OPEN);
      fail_q   <= (st_d == S_FAILSHOW) || (st_d == S_LOCKOUT);
      locked_q <= (st_d == S_LOCKOUT);
    end
  end

  assign pass      = pass_q;
  assign fail      = fail_q;
  assign locked    = locked_q;
  assign clr_entry = clr_q;
  assign st        = st_q;
  assign fails     = fails_q;
  assign remain    = remain_q;

endmodule

// File: tb/tb_lock_ctrl.sv
// Directed bench for lock_ctrl with hand-computed expectations.
module tb_lock_ctrl;

  logic        clk = 1'b0;
  logic        rst_n, tick, cnf, chg;
  logic [15:0] entry;
  logic        pass, fail, locked, clr_entry;
  logic [2:0]  st;
  logic [3:0]  fails;
  logic [7:0]  remain;

  int total = 0;
  int bad   = 0;

  lock_ctrl dut (
    .clk(clk), .rst_n(rst_n), .tick(tick), .cnf(cnf), .chg(chg), .entry(entry),
    .pass(pass), .fail(fail), .locked(locked), .clr_entry(clr_entry),
    .st(st), .fails(fails), .remain(remain)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_cnf(input logic [15:0] v);
    entry = v;
    cnf   = 1'b1;
    step();
    cnf   = 1'b0;
  endtask

  task automatic do_chg();
    chg = 1'b1;
    step();
    chg = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      tick = 1'b1;
      step();
      tick = 1'b0;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; tick = 1'b0; cnf = 1'b0; chg = 1'b0; entry = 16'h0;
    step(); step();
    chk("rst_st", st, 0);
    chk("rst_pass", pass, 0);
    chk("rst_fail", fail, 0);
    chk("rst_locked", locked, 0);
    chk("rst_clr", clr_entry, 0);
    chk("rst_fails", fails, 0);
    chk("rst_remain", remain, 0);
    rst_n = 1'b1;
    step();

    // 1: correct code opens for three ticks
    do_cnf(16'h1234);
    chk("t1_pass", pass, 1);
    chk("t1_st", st, 1);
    chk("t1_clr", clr_entry, 1);
    step();
    chk("t1_clr_off", clr_entry, 0);
    ticks(2);
    chk("t1_still_open", st, 1);
    ticks(1);
    chk("t1_st_idle", st, 0);
    chk("t1_pass_off", pass, 0);

    // 2: wrong code shows failure, cnf during FAILSHOW ignored
    do_cnf(16'h0000);
    chk("t2_fail", fail, 1);
    chk("t2_fails", fails, 1);
    chk("t2_st", st, 2);
    chk("t2_clr", clr_entry, 1);
    do_cnf(16'h1234);
    chk("t2_ign_clr", clr_entry, 0);
    chk("t2_ign_st", st, 2);
    ticks(3);
    chk("t2_idle", st, 0);
    chk("t2_fail_off", fail, 0);

    // 3: three wrong attempts lock out for ten ticks
    do_reset();
    do_cnf(16'h0000);
    ticks(3);
    do_cnf(16'h0001);
    chk("t3_fails2", fails, 2);
    chk("t3_st2", st, 2);
    ticks(3);
    do_cnf(16'h0002);
    chk("t3_st_lock", st, 3);
    chk("t3_locked", locked, 1);
    chk("t3_fail", fail, 1);
    chk("t3_remain10", remain, 10);
    chk("t3_fails3", fails, 3);
    ticks(1);
    chk("t3_remain9", remain, 9);
    do_cnf(16'h1234);
    chk("t3_ign_clr", clr_entry, 0);
    chk("t3_ign_st", st, 3);
    do_chg();
    chk("t3_ign_chg", st, 3);
    ticks(8);
    chk("t3_remain1", remain, 1);
    chk("t3_still_lock", st, 3);
    ticks(1);
    chk("t3_end_st", st, 0);
    chk("t3_end_remain", remain, 0);
    chk("t3_end_fails", fails, 0);
    chk("t3_end_locked", locked, 0);

    // 4: change code 1234 -> 5678
    do_chg();
    chk("t4_chg_st", st, 4);
    chk("t4_chg_clr", clr_entry, 0);
    do_cnf(16'h1234);
    chk("t4_new1", st, 5);
    chk("t4_new1_clr", clr_entry, 1);
    do_cnf(16'h5678);
    chk("t4_new2", st, 6);
    do_cnf(16'h5678);
    chk("t4_pass", pass, 1);
    chk("t4_open", st, 1);
    ticks(3);
    do_cnf(16'h1234);
    chk("t4_old_fails", st, 2);
    chk("t4_old_cnt", fails, 1);
    ticks(3);
    do_cnf(16'h5678);
    chk("t4_new_opens", pass, 1);
    chk("t4_fails_clr", fails, 0);
    ticks(3);

    // 5: mismatched repeat leaves code and fail count alone
    do_reset();
    do_cnf(16'h0000);
    ticks(3);
    do_chg();
    do_cnf(16'h1234);
    do_cnf(16'h5678);
    do_cnf(16'h5679);
    chk("t5_st", st, 2);
    chk("t5_fails", fails, 1);
    ticks(3);
    do_cnf(16'h1234);
    chk("t5_old_opens", st, 1);
    ticks(3);
    do_chg();
    do_cnf(16'h1234);
    chk("t5_new1", st, 5);
    do_chg();
    chk("t5_abort", st, 0);
    chk("t5_abort_clr", clr_entry, 0);

    // 6: reset mid-lockout restores initial code
    do_chg();
    do_cnf(16'h1234);
    do_cnf(16'h5678);
    do_cnf(16'h5678);
    chk("t6_open", st, 1);
    ticks(3);
    do_cnf(16'h0000);
    ticks(3);
    do_cnf(16'h0000);
    ticks(3);
    do_cnf(16'h0000);
    chk("t6_lock", st, 3);
    ticks(4);
    chk("t6_remain6", remain, 6);
    do_reset();
    chk("t6_rst_st", st, 0);
    chk("t6_rst_locked", locked, 0);
    chk("t6_rst_remain", remain, 0);
    chk("t6_rst_fails", fails, 0);
    do_cnf(16'h1234);
    chk("t6_init_opens", pass, 1);
    ticks(3);
    entry = 16'h0000;
    cnf = 1'b1;
    chg = 1'b1;
    step();
    cnf = 1'b0;
    chg = 1'b0;
    chk("t6_both_st", st, 2);
    chk("t6_both_fails", fails, 1);
    chk("t6_both_clr", clr_entry, 1);
    ticks(3);
    chk("t6_both_idle", st, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
